// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter for the single-port data memory, with RMW partial stores.
// Define DMEM_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins ties).
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [DATA_W/8-1:0]   m0_be,
    input  logic [ADDR_W-1:0]     m0_addr,
    input  logic [DATA_W-1:0]     m0_wdata,
    output logic                  m0_ack,
    output logic [DATA_W-1:0]     m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [DATA_W/8-1:0]   m1_be,
    input  logic [ADDR_W-1:0]     m1_addr,
    input  logic [DATA_W-1:0]     m1_wdata,
    output logic                  m1_ack,
    output logic [DATA_W-1:0]     m1_rdata,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wren,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int NB = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        MERGE,
        RESP
    } state_e;

    state_e              state_q, state_d;
    logic                gnt_q, gnt_d;
    logic                we_q, we_d;
    logic [NB-1:0]       be_q, be_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   mwdata_q, mwdata_d;
    logic [NB-1:0]       wren_q, wren_d;
    logic                ack0_q, ack0_d;
    logic                ack1_q, ack1_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d;
    logic [DATA_W-1:0]   rdata1_q, rdata1_d;
    logic                gnt_c;
    logic [DATA_W-1:0]   merged;

`ifdef DMEM_ARB_FIXED_PRIO_EN
    assign gnt_c = !m0_req;
`else
    // prio_q names the port that wins the next tie
    logic prio_q, prio_d;

    assign gnt_c = (m0_req && m1_req) ? prio_q : m1_req;

    always_comb begin
        prio_d = prio_q;
        if (state_q == IDLE && (m0_req || m1_req)) begin
            prio_d = !gnt_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end
`endif

    always_comb begin
        merged = mem_rdata;
        for (int i = 0; i < NB; i++) begin
            if (be_q[i]) begin
                merged[8*i +: 8] = wdata_q[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        we_d     = we_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        addr_d   = addr_q;
        mwdata_d = mwdata_q;
        wren_d   = '0;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        unique case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    gnt_d   = gnt_c;
                    we_d    = gnt_c ? m1_we    : m0_we;
                    be_d    = gnt_c ? m1_be    : m0_be;
                    wdata_d = gnt_c ? m1_wdata : m0_wdata;
                    addr_d  = gnt_c ? m1_addr  : m0_addr;
                    // full-word stores go straight out in XFER
                    if (we_d && be_d == '1) begin
                        wren_d   = '1;
                        mwdata_d = wdata_d;
                    end
                    state_d = XFER;
                end
            end
            XFER: begin
                if (!we_q) begin
                    if (gnt_q) begin
                        rdata1_d = mem_rdata;
                    end else begin
                        rdata0_d = mem_rdata;
                    end
                    state_d = RESP;
                end else if (be_q == '1 || be_q == '0) begin
                    state_d = RESP;
                end else begin
                    mwdata_d = merged;
                    wren_d   = '1;
                    state_d  = MERGE;
                end
                if (state_d == RESP) begin
                    ack0_d = !gnt_q;
                    ack1_d = gnt_q;
                end
            end
            MERGE: begin
                ack0_d  = !gnt_q;
                ack1_d  = gnt_q;
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            gnt_q    <= 1'b0;
            we_q     <= 1'b0;
            be_q     <= '0;
            wdata_q  <= '0;
            addr_q   <= '0;
            mwdata_q <= '0;
            wren_q   <= '0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            we_q     <= we_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            addr_q   <= addr_d;
            mwdata_q <= mwdata_d;
            wren_q   <= wren_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = mwdata_q;
    assign mem_wren  = wren_q;
    assign m0_ack    = ack0_q;
    assign m1_ack    = ack1_q;
    assign m0_rdata  = rdata0_q;
    assign m1_rdata  = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: vector table plus hand-built sequences
// for reset-in-MERGE, tie arbitration and a request arriving mid-RMW.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_req = 0, m0_we = 0;
    logic [3:0]  m0_be = 0;
    logic [31:0] m0_addr = 0, m0_wdata = 0;
    logic        m0_ack;
    logic [31:0] m0_rdata;
    logic        m1_req = 0, m1_we = 0;
    logic [3:0]  m1_be = 0;
    logic [31:0] m1_addr = 0, m1_wdata = 0;
    logic        m1_ack;
    logic [31:0] m1_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wren;

    int checks = 0;
    int failures = 0;
    int wren_cnt = 0;
    int bad_wren = 0;

    logic [31:0] mem [0:65535];

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[17:2]];

    always @(posedge clk) begin
        if (mem_wren != 4'h0) begin
            mem[mem_addr[17:2]] <= mem_wdata;
            wren_cnt <= wren_cnt + 1;
            if (mem_wren != 4'hF) bad_wren <= bad_wren + 1;
        end
    end

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wren(mem_wren), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic access(input int port, input logic we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output int lat, output logic [31:0] rd);
        lat = 0;
        rd  = '0;
        if (port == 0) begin
            m0_req = 1; m0_we = we; m0_be = be; m0_addr = addr; m0_wdata = wdata;
        end else begin
            m1_req = 1; m1_we = we; m1_be = be; m1_addr = addr; m1_wdata = wdata;
        end
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (port == 0 && m0_ack) begin
                lat = c; rd = m0_rdata; break;
            end
            if (port == 1 && m1_ack) begin
                lat = c; rd = m1_rdata; break;
            end
        end
        m0_req = 0;
        m1_req = 0;
    endtask

    typedef struct {
        int          port;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic        chk_rd;
        logic [31:0] rd;
        int          pulses;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int lat, w0, n, a0, a1;
        logic [31:0] rd;
        int gid [8];
        int gcyc [8];
        logic [31:0] grd [8];
        int exp_g;

        for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
        mem[32'h20 >> 2] = 32'h11223344;
        mem[32'h30 >> 2] = 32'h5A5A5A5A;
        mem[32'h40 >> 2] = 32'h77777777;
        mem[32'h50 >> 2] = 32'hFFFFFFFF;

        vecs[0] = '{0, 1, 4'hF, 32'h10, 32'hDEADBEEF, 2, 0, 32'h0, 1};
        vecs[1] = '{0, 0, 4'h0, 32'h10, 32'h0,        2, 1, 32'hDEADBEEF, 0};
        vecs[2] = '{1, 1, 4'h5, 32'h20, 32'hAABBCCDD, 3, 0, 32'h0, 1};
        vecs[3] = '{1, 0, 4'h0, 32'h20, 32'h0,        2, 1, 32'h11BB33DD, 0};
        vecs[4] = '{0, 1, 4'h0, 32'h30, 32'h12345678, 2, 0, 32'h0, 0};
        vecs[5] = '{0, 0, 4'h0, 32'h30, 32'h0,        2, 1, 32'h5A5A5A5A, 0};
        vecs[6] = '{1, 1, 4'h8, 32'h44, 32'h12345678, 3, 0, 32'h0, 1};
        vecs[7] = '{0, 0, 4'h0, 32'h44, 32'h0,        2, 1, 32'h12000000, 0};
        vecs[8] = '{1, 1, 4'hF, 32'h13, 32'hCAFEF00D, 2, 0, 32'h0, 1};
        vecs[9] = '{1, 0, 4'h0, 32'h11, 32'h0,        2, 1, 32'hCAFEF00D, 0};

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1;
        @(posedge clk);
        #1;
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_mem_wren", {28'h0, mem_wren}, 32'h0);
        chk("rst_acks", {30'h0, m1_ack, m0_ack}, 32'h0);
        chk("rst_rdata0", m0_rdata, 32'h0);
        chk("rst_rdata1", m1_rdata, 32'h0);

        for (int i = 0; i < 10; i++) begin
            w0 = wren_cnt;
            access(vecs[i].port, vecs[i].we, vecs[i].be, vecs[i].addr,
                   vecs[i].wdata, lat, rd);
            chk($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
            chk($sformatf("vec%0d_pulses", i), wren_cnt - w0, vecs[i].pulses);
            if (vecs[i].chk_rd) chk($sformatf("vec%0d_rdata", i), rd, vecs[i].rd);
            @(posedge clk);
            #1;
        end
        chk("mem_0x20_rmw", mem[32'h20 >> 2], 32'h11BB33DD);
        chk("mem_0x30_noop", mem[32'h30 >> 2], 32'h5A5A5A5A);

        // reset asserted during MERGE of a partial write
        w0 = wren_cnt;
        m0_req = 1; m0_we = 1; m0_be = 4'h3; m0_addr = 32'h40; m0_wdata = 32'h00001234;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("merge_wren_before_rst", {28'h0, mem_wren}, 32'hF);
        rst_n = 0;
        m0_req = 0;
        #1;
        chk("merge_rst_wren", {28'h0, mem_wren}, 32'h0);
        chk("merge_rst_ack", {31'h0, m0_ack}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1;
        chk("merge_rst_mem", mem[32'h40 >> 2], 32'h77777777);
        chk("merge_rst_pulses", wren_cnt - w0, 0);
        @(posedge clk); #1;
        chk("merge_rst_noack", {30'h0, m1_ack, m0_ack}, 32'h0);
        access(0, 0, 4'h0, 32'h40, 32'h0, lat, rd);
        chk("post_rst_lat", lat, 2);
        chk("post_rst_rdata", rd, 32'h77777777);
        @(posedge clk); #1;

        // both ports request continuously from a fresh reset
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
        m0_req = 1; m0_we = 0; m0_addr = 32'h10;
        m1_req = 1; m1_we = 0; m1_addr = 32'h20;
        n = 0;
        for (int c = 1; c <= 60 && n < 8; c++) begin
            @(posedge clk); #1;
            if (m0_ack) begin gid[n] = 0; gcyc[n] = c; grd[n] = m0_rdata; n++; end
            else if (m1_ack) begin gid[n] = 1; gcyc[n] = c; grd[n] = m1_rdata; n++; end
        end
        m0_req = 0;
        m1_req = 0;
        chk("tie_grant_count", n, 8);
        for (int i = 0; i < n; i++) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
            exp_g = 0;
`else
            exp_g = i % 2;
`endif
            chk($sformatf("tie_grant%0d", i), gid[i], exp_g);
            chk($sformatf("tie_rdata%0d", i), grd[i],
                exp_g == 0 ? 32'hCAFEF00D : 32'h11BB33DD);
            if (i > 0) chk($sformatf("tie_spacing%0d", i), gcyc[i] - gcyc[i-1], 3);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;

        // port 1 arrives while port 0's RMW is in flight
        a0 = 0;
        a1 = 0;
        rd = '0;
        m0_req = 1; m0_we = 1; m0_be = 4'h6; m0_addr = 32'h50; m0_wdata = 32'h0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                m1_req = 1; m1_we = 0; m1_addr = 32'h20;
            end
            if (m0_ack) begin a0 = c; m0_req = 0; end
            if (m1_ack) begin a1 = c; rd = m1_rdata; m1_req = 0; end
            if (a0 != 0 && a1 != 0) break;
        end
        m0_req = 0;
        m1_req = 0;
        chk("inflight_ack0_lat", a0, 3);
        chk("inflight_ack1_gap", a1 - a0, 3);
        chk("inflight_rdata1", rd, 32'h11BB33DD);
        chk("inflight_mem_0x50", mem[32'h50 >> 2], 32'hFF0000FF);
        chk("wren_values_legal", bad_wren, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
